// File: rtl/truco_pkg.sv
`default_nettype none
// ============================================================================
// Module   : truco_pkg
// Purpose  : Shared encodings for the truco hand controller: round results,
//            FSM states, hand-value ladder and player helpers.
// Revision : 1.0 - initial release
// ============================================================================
package truco_pkg;

  // Round result / hand winner encoding (also used for "last raiser").
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_TIE  = 2'b11;

  // Player encoding on raise_by.
  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;

  // Hand-value ladder.
  localparam logic [3:0] HV_1  = 4'd1;
  localparam logic [3:0] HV_3  = 4'd3;
  localparam logic [3:0] HV_6  = 4'd6;
  localparam logic [3:0] HV_9  = 4'd9;
  localparam logic [3:0] HV_12 = 4'd12;

  typedef enum logic [2:0] {
    ST_R1        = 3'd0,
    ST_R2        = 3'd1,
    ST_R3        = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_SCORE     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_e;

  // Next rung of the raise ladder; 12 saturates.
  function automatic logic [3:0] hv_next(input logic [3:0] v);
    case (v)
      HV_1:    hv_next = HV_3;
      HV_3:    hv_next = HV_6;
      HV_6:    hv_next = HV_9;
      default: hv_next = HV_12;
    endcase
  endfunction

  // Map a raise_by player bit onto the result encoding.
  function automatic logic [1:0] player_res(input logic by);
    player_res = (by == PLAYER_P2) ? RES_P2 : RES_P1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/truco_hand_judge.sv
`default_nettype none
// ============================================================================
// Module   : truco_hand_judge
// Purpose  : Combinational hand-winner decision from the three-round log.
// Revision : 1.0 - initial release
// ============================================================================
module truco_hand_judge
  import truco_pkg::*;
(
  input  logic [1:0] s1_i,
  input  logic [1:0] s2_i,
  input  logic [1:0] s3_i,
  input  logic [1:0] played_i,
  output logic       decided_o,
  output logic [1:0] winner_o
);

  logic [1:0] wins1;
  logic [1:0] wins2;

  // Unplayed slots hold RES_NONE, so counting over all slots is safe.
  assign wins1 = {1'b0, s1_i == RES_P1} + {1'b0, s2_i == RES_P1} + {1'b0, s3_i == RES_P1};
  assign wins2 = {1'b0, s1_i == RES_P2} + {1'b0, s2_i == RES_P2} + {1'b0, s3_i == RES_P2};

  // Two wins take the hand; otherwise ties defer to the first decisive round.
  always_comb begin
    decided_o = 1'b0;
    winner_o  = RES_NONE;
    if (wins1 >= 2'd2) begin
      decided_o = 1'b1;
      winner_o  = RES_P1;
    end else if (wins2 >= 2'd2) begin
      decided_o = 1'b1;
      winner_o  = RES_P2;
    end else if (played_i >= 2'd2 && ((s1_i == RES_TIE) != (s2_i == RES_TIE))) begin
      decided_o = 1'b1;
      winner_o  = (s1_i == RES_TIE) ? s2_i : s1_i;
    end else if (played_i == 2'd3) begin
      decided_o = 1'b1;
      if (s1_i == RES_TIE && s2_i == RES_TIE) begin
        winner_o = (s3_i == RES_TIE) ? RES_NONE : s3_i;
      end else begin
        winner_o = s1_i;  // 1-1 with a tied third round
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/truco_hand_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : truco_hand_ctrl
// Purpose  : Truco hand controller: round log, hand decision, raise/response
//            handshake and score accumulation up to game end.
// Revision : 1.0 - initial release
// ============================================================================
module truco_hand_ctrl
  import truco_pkg::*;
#(
  parameter int WIN_PTS = 12
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rnd_valid,
  input  logic [1:0] rnd_res,
  input  logic       raise_req,
  input  logic       raise_by,
  input  logic       resp_valid,
  input  logic       resp_acc,
  output logic [1:0] s1,
  output logic [1:0] s2,
  output logic [1:0] s3,
  output logic [3:0] hand_val,
  output logic       wait_resp,
  output logic [4:0] score1,
  output logic [4:0] score2,
  output logic       hand_done,
  output logic [1:0] hand_win,
  output logic       game_over,
  output logic       err
);

  localparam logic [5:0] WIN6 = 6'(WIN_PTS);

  state_e     state_q, resume_q;
  logic [1:0] s1_q, s2_q, s3_q;
  logic [3:0] hv_q;
  logic [1:0] last_q;
  logic       pend_by_q;
  logic       fold_q;
  logic [4:0] score1_q, score2_q;
  logic [4:0] score1_d, score2_d;
  logic       hand_done_q, game_over_q, err_q;
  logic [1:0] hand_win_q;

  logic [1:0] played;
  logic       judge_dec;
  logic [1:0] judge_win;
  logic       decided;
  logic       raise_ok;
  logic       any_in;
  logic       game_end;
  logic [5:0] sum1, sum2;

  assign played   = {1'b0, s1_q != RES_NONE} + {1'b0, s2_q != RES_NONE} + {1'b0, s3_q != RES_NONE};
  assign decided  = judge_dec | fold_q;
  assign raise_ok = (hv_q != HV_12) && (last_q != player_res(raise_by));
  assign any_in   = rnd_valid | raise_req | resp_valid;

  truco_hand_judge u_judge (
    .s1_i      (s1_q),
    .s2_i      (s2_q),
    .s3_i      (s3_q),
    .played_i  (played),
    .decided_o (judge_dec),
    .winner_o  (judge_win)
  );

  // Scores after awarding the current hand value to hand_win_q, clamped.
  always_comb begin
    sum1     = {1'b0, score1_q} + ((hand_win_q == RES_P1) ? {2'b00, hv_q} : 6'd0);
    sum2     = {1'b0, score2_q} + ((hand_win_q == RES_P2) ? {2'b00, hv_q} : 6'd0);
    score1_d = (sum1 >= WIN6) ? WIN6[4:0] : sum1[4:0];
    score2_d = (sum2 >= WIN6) ? WIN6[4:0] : sum2[4:0];
    game_end = ({1'b0, score1_d} == WIN6) || ({1'b0, score2_d} == WIN6);
  end

  // Hand FSM with registered outputs; a decided hand is judged from the
  // registered log one cycle after the deciding input.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_R1;
      resume_q    <= ST_R1;
      s1_q        <= RES_NONE;
      s2_q        <= RES_NONE;
      s3_q        <= RES_NONE;
      hv_q        <= HV_1;
      last_q      <= RES_NONE;
      pend_by_q   <= 1'b0;
      fold_q      <= 1'b0;
      score1_q    <= 5'd0;
      score2_q    <= 5'd0;
      hand_done_q <= 1'b0;
      hand_win_q  <= RES_NONE;
      game_over_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hand_done_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ST_R1, ST_R2, ST_R3: begin
          if (decided) begin
            state_q     <= ST_SCORE;
            hand_done_q <= 1'b1;
            hand_win_q  <= fold_q ? player_res(pend_by_q) : judge_win;
            fold_q      <= 1'b0;
            err_q       <= any_in;
          end else if (raise_req) begin
            // A raise wins over a coincident round, which is dropped.
            err_q <= rnd_valid | resp_valid | !raise_ok;
            if (raise_ok) begin
              state_q   <= ST_WAIT_RESP;
              resume_q  <= state_q;
              pend_by_q <= raise_by;
            end
          end else if (rnd_valid) begin
            err_q <= resp_valid | (rnd_res == RES_NONE);
            if (rnd_res != RES_NONE) begin
              case (state_q)
                ST_R1: begin
                  s1_q    <= rnd_res;
                  state_q <= ST_R2;
                end
                ST_R2: begin
                  s2_q    <= rnd_res;
                  state_q <= ST_R3;
                end
                default: s3_q <= rnd_res;
              endcase
            end
          end else begin
            err_q <= resp_valid;
          end
        end
        ST_WAIT_RESP: begin
          err_q <= rnd_valid | raise_req;
          if (resp_valid) begin
            state_q <= resume_q;
            if (resp_acc) begin
              hv_q   <= hv_next(hv_q);
              last_q <= player_res(pend_by_q);
            end else begin
              fold_q <= 1'b1;  // raiser takes the hand at the unraised value
            end
          end
        end
        ST_SCORE: begin
          err_q      <= any_in;
          score1_q   <= score1_d;
          score2_q   <= score2_d;
          s1_q       <= RES_NONE;
          s2_q       <= RES_NONE;
          s3_q       <= RES_NONE;
          hv_q       <= HV_1;
          last_q     <= RES_NONE;
          hand_win_q <= RES_NONE;
          if (game_end) begin
            state_q     <= ST_GAME_OVER;
            game_over_q <= 1'b1;
          end else begin
            state_q <= ST_R1;
          end
        end
        default: err_q <= any_in;
      endcase
    end
  end

  assign s1        = s1_q;
  assign s2        = s2_q;
  assign s3        = s3_q;
  assign hand_val  = hv_q;
  assign wait_resp = (state_q == ST_WAIT_RESP);
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign hand_done = hand_done_q;
  assign hand_win  = hand_win_q;
  assign game_over = game_over_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: doc/truco_hand_ctrl.md
# truco_hand_ctrl

Hand-level controller for the truco game. Collects per-round results, keeps the three-round log, resolves the hand winner under tie rules, runs the truco raise/response handshake (1→3→6→9→12), and accumulates both players' scores up to game end. Sits downstream of the round-result source and upstream of score/display logic; its round-log outputs use the existing 2-bit round encoding.

## Interface

Parameters:
- WIN_PTS, 12, game-ending score; scores clamp at this value.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-low reset.
- rnd_valid  in  1  one-cycle pulse: round result present.
- rnd_res  in  2  01 = P1 wins round, 10 = P2, 11 = tie, 00 = illegal.
- raise_req  in  1  one-cycle pulse: truco/raise request.
- raise_by  in  1  raiser: 0 = P1, 1 = P2.
- resp_valid  in  1  one-cycle pulse: opponent answers pending raise.
- resp_acc  in  1  1 = accept, 0 = run (fold).
- s1, s2, s3  out  2 each  round 1/2/3 log, same encoding; 00 = not played.
- hand_val  out  4  current hand value (1, 3, 6, 9, 12).
- wait_resp  out  1  raise pending.
- score1, score2  out  5 each  accumulated points.
- hand_done  out  1  one-cycle pulse: hand resolved.
- hand_win  out  2  01 P1, 10 P2, 00 nobody; valid while hand_done.
- game_over  out  1  level; a score reached WIN_PTS.
- err  out  1  one-cycle pulse: input dropped/illegal.

## Operation

- States: R1, R2, R3 (awaiting round k), WAIT_RESP, SCORE, GAME_OVER.
- Reset: state R1; s1..s3 = 00; hand_val = 1; scores 0; last raiser = none; all pulses 0; game_over 0.
- Round accept (R1/R2/R3, legal rnd_res): write log slot k; run hand decision.
- Hand decision after each round:
  - a player with 2 round wins wins the hand;
  - r1 tie: r2 winner wins; r1, r2 tie: r3 winner wins;
  - r1 won by X, r2 tie: X wins;
  - after r3 with 1–1 and r3 tie: r1 winner wins;
  - all three tied: hand_win = 00, no points.
  - Decided → SCORE; else next Rk.
- Raise (R-states only): legal if hand_val < 12 and raise_by ≠ last raiser → WAIT_RESP, remember raiser and resume state.
- WAIT_RESP: accept → hand_val steps one ladder level, last raiser = raise_by, return to resume state; run → hand won by raiser at pre-raise hand_val → SCORE.
- SCORE: hand_done = 1; winner score += hand_val, clamped at WIN_PTS; clear log, hand_val = 1, last raiser = none; → GAME_OVER if a score reaches WIN_PTS, else R1.
- GAME_OVER: hold everything; only clr exits.
- err pulses for: rnd_res = 00; rnd_valid in WAIT_RESP/SCORE/GAME_OVER; illegal raise; resp_valid outside WAIT_RESP; raise_req and rnd_valid in the same cycle (raise processed, round dropped). Dropped inputs change no state.

## Timing

- Input at edge N → log / hand_val / wait_resp visible after edge N.
- Deciding round or run at edge N → state SCORE during cycle N+1, with hand_done and hand_win asserted.
- Scores, cleared log, and hand_val = 1 visible after edge N+2.
- game_over rises together with the final score update.
- resp_valid in the same cycle that WAIT_RESP is entered is err; the earliest legal response is the next cycle.
- clr low mid-hand or mid-raise: immediate return to reset values, no pulses emitted.

## Structure

- truco_pkg: result encodings (RES_P1, RES_P2, RES_TIE, RES_NONE), state enum, hand-value ladder constants, player encoding.
- Sub-module truco_hand_judge: combinational; inputs s1..s3 and rounds-played; outputs decided and winner. The controller FSM instantiates it.

## Test plan

- After reset, rounds 01, 01 → hand_done after round 2 with hand_win 01; score1 = 1; log cleared.
- Rounds 11, 10 → P2 wins; rounds 01, 11 → P1 wins; rounds 11, 11, 11 → hand_win 00, scores unchanged.
- P1 raises, P2 accepts, P2 raises, P1 accepts → hand_val 6; rounds 10, 10 → score2 += 6. A second P1 raise before P2 re-raises → err pulse, hand_val unchanged.
- P1 raises at hand_val 3, P2 runs → hand_done, hand_win 01, score1 += 3.
- score1 = 10, P1 wins a 3-point hand → score1 = 12, game_over = 1; further rnd_valid → err only.
- clr low while in WAIT_RESP → all outputs at reset values; raise_req together with rnd_valid → raise taken, round dropped, err pulse.
